seq_multiplier: RTL and testbench
=================================

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter N, default 8: operand width in bits, legal range 2..32.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port valid_i, input, 1 bit: producer has an operand pair on a, b, signed_i.
REQ-005 SHALL have port ready_i, output, 1 bit: block can accept an operand pair this cycle.
REQ-006 SHALL have ports a and b, input, N bits each: the operands.
REQ-007 SHALL have port signed_i, input, 1 bit: 1 = two's-complement operands, 0 = unsigned.
REQ-008 SHALL have port valid_o, output, 1 bit: product is valid.
REQ-009 SHALL have port ready_o, input, 1 bit: consumer accepts product this cycle.
REQ-010 SHALL have port product, output, 2N bits: the result.

Function
REQ-011 SHALL implement states IDLE, BUSY and DONE.
REQ-012 SHALL drive ready_i = (state==IDLE) | (state==DONE & ready_o).
REQ-013 SHALL accept a pair on a rising edge with valid_i & ready_i; this latches a, b, signed_i, loads the step counter with N and enters BUSY.
REQ-014 SHALL ignore a, b and signed_i at all times other than an accepting edge.
REQ-015 SHALL in BUSY perform one shift-add step per cycle on operand magnitudes: add the multiplicand when the multiplier LSB is 1, shift, decrement the counter.
REQ-016 SHALL enter DONE when the counter reaches 0, giving exactly N BUSY cycles; valid_o rises N cycles after the accepting edge.
REQ-017 SHALL in signed mode take magnitudes at accept and negate the 2N-bit result when operand signs differ; the most negative value (-2^(N-1)) SHALL be handled exactly.
REQ-018 SHALL produce the exact 2N-bit product in both modes; no overflow is possible.
REQ-019 SHALL assert valid_o only in DONE and hold product and valid_o stable while ready_o is 0.
REQ-020 SHALL on valid_o & ready_o go to IDLE, or to BUSY when valid_i is also 1 (back-to-back: simultaneous output and input handshake on one edge).
REQ-021 SHALL keep product at its last value in IDLE and BUSY, with valid_o = 0.

Reset
REQ-022 SHALL on rst=0, asynchronously and regardless of state, go to IDLE and clear valid_o, product, the counter and the accumulator to 0; an in-flight operation is discarded.
REQ-023 SHALL drive ready_i = 1 during reset and on the first edge after release.

Configuration
REQ-024 SHALL compile early termination in when SEQ_MULTIPLIER_EARLY_EXIT_EN is defined: BUSY ends after the step in which the remaining multiplier magnitude bits become 0 (minimum 1 BUSY cycle; a multiplier of 0 takes 1 cycle).
REQ-025 SHALL, without SEQ_MULTIPLIER_EARLY_EXIT_EN, always take exactly N BUSY cycles.
REQ-026 SHALL give identical products in both configurations; only latency differs.

Structure
REQ-027 SHALL place the state enum (IDLE/BUSY/DONE) in a shared package seq_multiplier_pkg.
REQ-028 SHALL place a function returning the counter width $clog2(N+1) in seq_multiplier_pkg.
REQ-029 SHALL keep the accumulator/shift/negate datapath in one sub-module, seq_multiplier_datapath; the FSM and handshake remain in seq_multiplier.

Verification (N=8 unless stated)
REQ-030 SHALL check unsigned 255*255 -> product 0xFE01, valid_o exactly 8 cycles after accept (no macro).
REQ-031 SHALL check signed -128*-128 -> 0x4000; signed -1*127 -> 0xFF81; signed -128*1 -> 0xFF80.
REQ-032 SHALL check backpressure: hold ready_o=0 for 5 cycles in DONE -> valid_o and product unchanged, ready_i=0; then the product is released.
REQ-033 SHALL check back-to-back: second pair 3*5 offered while DONE & ready_o -> accepted on the same edge, product 15 valid 8 cycles later.
REQ-034 SHALL check reset mid-BUSY: rst=0 at step 4 -> immediately IDLE, valid_o=0, product=0; the next op 7*6 -> 42.
REQ-035 SHALL check with SEQ_MULTIPLIER_EARLY_EXIT_EN: unsigned 200*1 -> 200 after 1 BUSY cycle; 0*0 -> 0 after 1 cycle; 1000 random pairs in both modes match the behavioural a*b.

Source files
------------

// File: rtl/seq_multiplier_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Holds the FSM state encoding and the step-counter width helper.
package seq_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_multiplier_datapath.sv
// Magnitude shift-add datapath: one step per i_step cycle, sign fixed up on the last step.
// Early termination compiled in with SEQ_MULTIPLIER_EARLY_EXIT_EN; no backpressure (driven by FSM).
module seq_multiplier_datapath
  import seq_multiplier_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_load,
  input  logic           i_step,
  input  logic [N-1:0]   i_a,
  input  logic [N-1:0]   i_b,
  input  logic           i_signed,
  output logic           o_last,
  output logic [2*N-1:0] o_product
);

  localparam int CW = cnt_width(N);

  logic [2*N-1:0] r_acc;
  logic [2*N-1:0] r_mcand;
  logic [N-1:0]   r_mplier;
  logic           r_neg;
  logic [CW-1:0]  r_cnt;
  logic [2*N-1:0] r_product;

  logic [N-1:0]   w_mag_a;
  logic [N-1:0]   w_mag_b;
  logic           w_neg;
  logic [2*N-1:0] w_acc_next;
  logic [N-1:0]   w_mplier_next;
  logic           w_last;

  // -2^(N-1) negates to itself, which read as unsigned is the correct magnitude.
  always_comb begin
    w_mag_a       = (i_signed && i_a[N-1]) ? -i_a : i_a;
    w_mag_b       = (i_signed && i_b[N-1]) ? -i_b : i_b;
    w_neg         = i_signed && (i_a[N-1] ^ i_b[N-1]);
    w_acc_next    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    w_mplier_next = r_mplier >> 1;
`ifdef SEQ_MULTIPLIER_EARLY_EXIT_EN
    w_last        = (r_cnt == CW'(1)) || (w_mplier_next == '0);
`else
    w_last        = (r_cnt == CW'(1));
`endif
  end

  assign o_last    = i_step & w_last;
  assign o_product = r_product;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_neg     <= 1'b0;
      r_cnt     <= '0;
      r_product <= '0;
    end else if (i_load) begin
      r_acc     <= '0;
      r_mcand   <= {{N{1'b0}}, w_mag_a};
      r_mplier  <= w_mag_b;
      r_neg     <= w_neg;
      r_cnt     <= CW'(N);
    end else if (i_step) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= w_mplier_next;
      r_cnt    <= r_cnt - 1'b1;
      if (w_last) begin
        r_product <= r_neg ? -w_acc_next : w_acc_next;
      end
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential N x N multiplier (signed/unsigned), N BUSY cycles per product (fewer with SEQ_MULTIPLIER_EARLY_EXIT_EN).
// Valid/ready on both sides; result held in DONE until ready_o, with same-edge back-to-back accept.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           valid_i,
  output logic           ready_i,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           signed_i,
  output logic           valid_o,
  input  logic           ready_o,
  output logic [2*N-1:0] product
);

  state_e r_state;
  state_e w_state_next;
  logic   w_accept;
  logic   w_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    ready_i      = 1'b0;
    valid_o      = 1'b0;
    unique case (r_state)
      IDLE: begin
        ready_i = 1'b1;
        if (valid_i) w_state_next = BUSY;
      end
      BUSY: begin
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        valid_o = 1'b1;
        ready_i = ready_o;
        if (ready_o) w_state_next = valid_i ? BUSY : IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    w_accept = valid_i & ready_i;
  end

  seq_multiplier_datapath #(
    .N(N)
  ) u_datapath (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_accept),
    .i_step   (r_state == BUSY),
    .i_a      (a),
    .i_b      (b),
    .i_signed (signed_i),
    .o_last   (w_last),
    .o_product(product)
  );

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier (N=8): directed corner cases, backpressure,
// back-to-back, mid-operation reset and random traffic in both signedness modes.
module tb_seq_multiplier;

  localparam int N = 8;

  typedef struct {
    logic [2*N-1:0] prod;
    int             lat;
    int             acc_cyc;
  } exp_t;

  logic           clk;
  logic           rst;
  logic           valid_i;
  logic           ready_i;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           signed_i;
  logic           valid_o;
  logic           ready_o;
  logic [2*N-1:0] product;

  int   checks = 0;
  int   errs   = 0;
  int   cyc    = 0;
  exp_t sb[$];
  logic seen;
  int   rise_cyc;
  int   last_acc;
  int   last_out;

  seq_multiplier #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .valid_i (valid_i),
    .ready_i (ready_i),
    .a       (a),
    .b       (b),
    .signed_i(signed_i),
    .valid_o (valid_o),
    .ready_o (ready_o),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [2*N-1:0] model(input logic [N-1:0] x, input logic [N-1:0] y, input logic s);
    logic signed [2*N-1:0] sx;
    logic signed [2*N-1:0] sy;
    sx = {{N{x[N-1]}}, x};
    sy = {{N{y[N-1]}}, y};
    if (s) return sx * sy;
    return {{N{1'b0}}, x} * {{N{1'b0}}, y};
  endfunction

  function automatic int exp_lat(input logic [N-1:0] y, input logic s);
    logic [N-1:0] m;
    int l;
    m = (s && y[N-1]) ? -y : y;
    l = N;
`ifdef SEQ_MULTIPLIER_EARLY_EXIT_EN
    l = 1;
    for (int i = 0; i < N; i++) if (m[i]) l = i + 1;
`else
    if (m === 'x) l = 0;
`endif
    return l;
  endfunction

  // Output side: product and latency compared when the output handshake is seen.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      seen = 1'b0;
    end else if (valid_o) begin
      if (!seen) begin
        rise_cyc = cyc;
        seen     = 1'b1;
      end
      if (ready_o) begin
        last_out = cyc + 1;
        if (sb.size() == 0) begin
          chk("unexpected_output", 64'(valid_o), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("product", 64'(product), 64'(e.prod));
          chk("latency", 64'(rise_cyc - e.acc_cyc), 64'(e.lat));
        end
        seen = 1'b0;
      end
    end
  end

  // Called away from clock edges; returns #1 after the accepting edge.
  task automatic send(input logic [N-1:0] ia, input logic [N-1:0] ib, input logic is,
                      input logic [2*N-1:0] ep);
    bit ok;
    int k;
    exp_t e;
    a = ia; b = ib; signed_i = is; valid_i = 1'b1;
    ok = 0; k = 0;
    while (!ok && k < 200) begin
      @(negedge clk);
      if (ready_i) ok = 1; else k++;
    end
    if (!ok) begin
      chk("accept_timeout", 64'd0, 64'd1);
      valid_i = 1'b0;
      return;
    end
    e.prod = ep; e.lat = exp_lat(ib, is); e.acc_cyc = cyc + 1;
    sb.push_back(e);
    last_acc = cyc + 1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    a = N'($urandom); b = N'($urandom); signed_i = 1'($urandom);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [N-1:0] x, y;
    logic s;
    int k;
    rst = 1'b0; valid_i = 1'b0; ready_o = 1'b1;
    a = '0; b = '0; signed_i = 1'b0;
    seen = 1'b0; rise_cyc = 0; last_acc = 0; last_out = -1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready_i", 64'(ready_i), 64'd1);
    chk("rst_valid_o", 64'(valid_o), 64'd0);
    chk("rst_product", 64'(product), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready_i", 64'(ready_i), 64'd1);

    send(8'd255, 8'd255, 1'b0, 16'hFE01); drain();
    send(8'h80, 8'h80, 1'b1, 16'h4000);   drain();
    send(8'hFF, 8'h7F, 1'b1, 16'hFF81);   drain();
    send(8'h80, 8'h01, 1'b1, 16'hFF80);   drain();
    send(8'd200, 8'd1, 1'b0, 16'd200);    drain();
    send(8'd0, 8'd0, 1'b0, 16'd0);        drain();
    send(8'hFF, 8'hFF, 1'b0, 16'hFE01);   drain();

    // Backpressure: result must sit unchanged in DONE.
    ready_o = 1'b0;
    send(8'd12, 8'd11, 1'b0, 16'd132);
    k = 0;
    while (!valid_o && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_valid_o", 64'(valid_o), 64'd1);
      chk("bp_product", 64'(product), 64'd132);
      chk("bp_ready_i", 64'(ready_i), 64'd0);
    end
    ready_o = 1'b1;
    drain();

    // Back-to-back: second pair accepted on the output handshake edge.
    send(8'd255, 8'd255, 1'b0, 16'hFE01);
    send(8'd3, 8'd5, 1'b0, 16'd15);
    chk("b2b_same_edge", 64'(last_acc), 64'(last_out));
    drain();

    // Reset in the middle of an operation.
    send(8'd100, 8'd100, 1'b0, 16'd10000);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    sb.delete();
    chk("midrst_ready_i", 64'(ready_i), 64'd1);
    chk("midrst_valid_o", 64'(valid_o), 64'd0);
    chk("midrst_product", 64'(product), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    send(8'd7, 8'd6, 1'b0, 16'd42);
    drain();

    for (int i = 0; i < 2000; i++) begin
      x = N'($urandom);
      y = N'($urandom);
      s = (i >= 1000);
      send(x, y, s, model(x, y, s));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
